// File: rtl/aer_channel_arbiter.sv
// Round-robin arbiter sharing one 4-line AER channel among N_SRC spike sources.
// Runs a 4-phase return-to-zero handshake per event with a per-phase abort timer.
module aer_channel_arbiter #(
  parameter int unsigned N_SRC   = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_SRC-1:0]   req,
  input  logic [2*N_SRC-1:0] evt,
  input  logic               ack_in,
  output logic [3:0]         ch_out,
  output logic [N_SRC-1:0]   done,
  output logic               busy,
  output logic [ID_W-1:0]    grant_id,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   err_cnt
);

  typedef enum logic [1:0] {IDLE, DRIVE, RELEASE, RECOVER} state_t;

  state_t             state_q, state_d;
  logic               ack_meta_q, ack_meta_d;
  logic               ack_s_q, ack_s_d;
  logic [3:0]         ch_out_q, ch_out_d;
  logic [N_SRC-1:0]   done_q, done_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic               timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [CNT_W-1:0]   timer_q, timer_d;

  logic               pick_found;
  logic [ID_W-1:0]    pick_id;
  logic [ID_W:0]      pick_idx;
  logic [ID_W-1:0]    grant_next;
  logic [CNT_W:0]     timer_inc;
  logic               expired;
  logic               do_abort;

  // First requester at or after the round-robin pointer, wrapping modulo N_SRC.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    pick_idx   = '0;
    for (int unsigned off = 0; off < N_SRC; off++) begin
      pick_idx = {1'b0, rr_q} + (ID_W+1)'(off);
      if (pick_idx >= (ID_W+1)'(N_SRC)) pick_idx = pick_idx - (ID_W+1)'(N_SRC);
      if (!pick_found && req[pick_idx[ID_W-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = pick_idx[ID_W-1:0];
      end
    end
  end

  assign grant_next = (grant_id_q == ID_W'(N_SRC-1)) ? '0 : grant_id_q + 1'b1;
  assign timer_inc  = {1'b0, timer_q} + 1'b1;
  assign expired    = (timer_inc == (CNT_W+1)'(TIMEOUT));

  always_comb begin
    state_d       = state_q;
    ack_meta_d    = ack_in;
    ack_s_d       = ack_meta_q;
    ch_out_d      = ch_out_q;
    done_d        = '0;
    grant_id_d    = grant_id_q;
    timeout_err_d = 1'b0;
    err_cnt_d     = err_cnt_q;
    rr_d          = rr_q;
    timer_d       = timer_q;
    do_abort      = 1'b0;
    case (state_q)
      IDLE: begin
        ch_out_d = '0;
        if (pick_found && !ack_s_q) begin
          grant_id_d = pick_id;
          ch_out_d   = 4'b0001 << evt[2*pick_id +: 2];
          timer_d    = '0;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        if (ack_s_q) begin
          ch_out_d = '0;
          timer_d  = '0;
          state_d  = RELEASE;
        end else if (expired) begin
          do_abort = 1'b1;
        end else begin
          timer_d = timer_inc[CNT_W-1:0];
        end
      end
      RELEASE: begin
        if (!ack_s_q) begin
          done_d[grant_id_q] = 1'b1;
          rr_d    = grant_next;
          state_d = IDLE;
        end else if (expired) begin
          do_abort = 1'b1;
        end else begin
          timer_d = timer_inc[CNT_W-1:0];
        end
      end
      RECOVER: begin
        ch_out_d = '0;
        if (!ack_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The phase condition is tested first above, so it wins over a same-cycle expiry.
    if (do_abort) begin
      ch_out_d      = '0;
      timeout_err_d = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      rr_d          = grant_next;
      state_d       = RECOVER;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      ack_meta_q    <= 1'b0;
      ack_s_q       <= 1'b0;
      ch_out_q      <= '0;
      done_q        <= '0;
      grant_id_q    <= '0;
      timeout_err_q <= 1'b0;
      err_cnt_q     <= '0;
      rr_q          <= '0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      ack_meta_q    <= ack_meta_d;
      ack_s_q       <= ack_s_d;
      ch_out_q      <= ch_out_d;
      done_q        <= done_d;
      grant_id_q    <= grant_id_d;
      timeout_err_q <= timeout_err_d;
      err_cnt_q     <= err_cnt_d;
      rr_q          <= rr_d;
      timer_q       <= timer_d;
    end
  end

  assign ch_out      = ch_out_q;
  assign done        = done_q;
  assign busy        = (state_q != IDLE);
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_aer_channel_arbiter.sv
// Directed and randomized bench for aer_channel_arbiter against a transaction-level
// model of arbitration order, event decode, handshake timing and abort counting.
module tb_aer_channel_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [7:0] evt;
  logic       ack_in;
  logic [3:0] ch_out;
  logic [3:0] done;
  logic       busy;
  logic [1:0] grant_id;
  logic       timeout_err;
  logic [7:0] err_cnt;

  logic [3:0] sat_req;
  logic [7:0] sat_evt;
  logic       sat_ack;
  logic [3:0] sat_ch_out;
  logic [3:0] sat_done;
  logic       sat_busy;
  logic [1:0] sat_grant;
  logic       sat_terr;
  logic [1:0] sat_err;

  int checks = 0;
  int errors = 0;
  int rr_m   = 0;
  int errm   = 0;
  int w      = 0;
  logic [3:0] exp_ch;

  always #5 clk = ~clk;

  aer_channel_arbiter #(.N_SRC(4), .ID_W(2), .TIMEOUT(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .evt(evt), .ack_in(ack_in),
    .ch_out(ch_out), .done(done), .busy(busy), .grant_id(grant_id),
    .timeout_err(timeout_err), .err_cnt(err_cnt)
  );

  aer_channel_arbiter #(.N_SRC(4), .ID_W(2), .TIMEOUT(3), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .req(sat_req), .evt(sat_evt), .ack_in(sat_ack),
    .ch_out(sat_ch_out), .done(sat_done), .busy(sat_busy), .grant_id(sat_grant),
    .timeout_err(sat_terr), .err_cnt(sat_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] rq, input int rr);
    for (int off = 0; off < 4; off++) begin
      if (rq[(rr + off) % 4]) return (rr + off) % 4;
    end
    return 0;
  endfunction

  // Present a request pattern at an idle point; grant is visible one cycle later.
  task automatic grant(input logic [3:0] rq, input logic [7:0] ev, input bit drop);
    req = rq;
    evt = ev;
    @(negedge clk);
    w = pick(rq, rr_m);
    exp_ch = 4'b0001 << ev[2*w +: 2];
    chk("grant_busy", busy, 1);
    chk("grant_id", grant_id, w);
    chk("grant_ch", ch_out, exp_ch);
    chk("done_clear", done, 0);
    evt = 8'($urandom);
    if (drop) req = '0;
  endtask

  // mode 0: normal, 1: dead channel (no ack), 2: ack stuck high after DRIVE
  task automatic handshake(input int mode, input int k, input int j);
    if (mode == 1) begin
      for (int t = 1; t <= 7; t++) begin
        @(negedge clk); chk("dead_hold", ch_out, exp_ch);
      end
      @(negedge clk);
      errm = (errm < 255) ? errm + 1 : 255;
      rr_m = (w + 1) % 4;
      chk("dead_ch", ch_out, 0);
      chk("dead_err", timeout_err, 1);
      chk("dead_cnt", err_cnt, errm);
      chk("dead_nodone", done, 0);
      chk("dead_busy", busy, 1);
      @(negedge clk);
      chk("dead_idle", busy, 0);
      chk("dead_pulse", timeout_err, 0);
      return;
    end
    for (int t = 0; t < k; t++) begin
      @(negedge clk); chk("drive_hold", ch_out, exp_ch);
    end
    ack_in = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      if (t < 3) chk("ack_sync", ch_out, exp_ch);
      else begin
        chk("rel_ch", ch_out, 0);
        chk("rel_busy", busy, 1);
        chk("rel_done", done, 0);
      end
    end
    if (mode == 0) begin
      for (int t = 0; t < j; t++) begin
        @(negedge clk); chk("rel_hold", busy, 1);
      end
      ack_in = 1'b0;
      for (int t = 1; t <= 3; t++) begin
        @(negedge clk);
        if (t < 3) chk("done_wait", done, 0);
        else begin
          chk("done_pulse", done, 4'b0001 << w);
          chk("done_idle", busy, 0);
          chk("done_noerr", timeout_err, 0);
        end
      end
      rr_m = (w + 1) % 4;
    end else begin
      for (int t = 1; t <= 7; t++) begin
        @(negedge clk); chk("stuck_hold", timeout_err, 0);
      end
      @(negedge clk);
      errm = (errm < 255) ? errm + 1 : 255;
      rr_m = (w + 1) % 4;
      chk("stuck_err", timeout_err, 1);
      chk("stuck_cnt", err_cnt, errm);
      chk("stuck_nodone", done, 0);
      for (int t = 0; t < int'($urandom_range(1, 3)); t++) begin
        @(negedge clk);
        chk("recover_busy", busy, 1);
        chk("recover_ch", ch_out, 0);
      end
      ack_in = 1'b0;
      for (int t = 1; t <= 3; t++) begin
        @(negedge clk);
        chk("recover_exit", busy, (t < 3) ? 1 : 0);
      end
    end
  endtask

  initial begin
    int r, pulses;
    reset = 1'b1; req = '0; evt = '0; ack_in = 1'b0;
    sat_req = '0; sat_evt = '0; sat_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ch", ch_out, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_cnt", err_cnt, 0);
    reset = 1'b0;

    // Round robin with all four requests held
    for (int n = 0; n < 5; n++) begin
      grant(4'hF, 8'h00, 1'b0);
      handshake(0, 1, 1);
    end
    // Single source, Ch2Up, ack after 3 cycles
    grant(4'b0001, 8'b0000_0010, 1'b1);
    handshake(0, 3, 2);
    // Dead channel, then the other source is served next
    grant(4'b0011, 8'h1B, 1'b0);
    handshake(1, 0, 0);
    grant(4'b0011, 8'h1B, 1'b1);
    handshake(0, 5, 5);
    // Ack stuck high in the release phase
    grant(4'b1000, 8'h40, 1'b1);
    handshake(2, 2, 0);
    // No grant while the channel ack is still high in IDLE
    req = '0;
    ack_in = 1'b1;
    repeat (3) @(negedge clk);
    req = 4'b0100;
    evt = 8'h30;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("ackhi_nogrant", ch_out, 0);
      chk("ackhi_idle", busy, 0);
    end
    ack_in = 1'b0;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk); chk("ackhi_wait", busy, 0);
    end
    grant(4'b0100, 8'h30, 1'b1);
    handshake(0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      grant(4'($urandom_range(1, 15)), 8'($urandom), 1'($urandom_range(0, 1)));
      handshake((r < 6) ? 0 : (r < 8) ? 1 : 2, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
    end

    // Reset in the middle of DRIVE
    grant(4'b0001, 8'h00, 1'b0);
    reset = 1'b1;
    req = '0;
    @(negedge clk);
    chk("mid_rst_ch", ch_out, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_gid", grant_id, 0);
    chk("mid_rst_terr", timeout_err, 0);
    chk("mid_rst_cnt", err_cnt, 0);
    reset = 1'b0;
    rr_m = 0;
    errm = 0;
    grant(4'hF, 8'hE4, 1'b1);
    handshake(0, 2, 1);

    // Abort counter saturation on the narrow-counter instance
    pulses = 0;
    sat_req = 4'b0001;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      if (sat_terr) begin
        pulses++;
        chk("sat_step", sat_err, (pulses > 3) ? 3 : pulses);
      end
    end
    sat_req = '0;
    chk("sat_aborts", (pulses >= 5) ? 1 : 0, 1);
    chk("sat_final", sat_err, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
